// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants for the multi-channel clock divider
//
// Holds the system clock rate, the standard half-period presets and the
// width of the reload channel index. Imported by clk_div_chan and
// clk_divider_multi.

package clk_div_pkg;

    localparam int CLK_IN_HZ = 50_000_000;

    // Half-periods in 50 MHz input cycles
    localparam int HALF_1K   = 25000;
    localparam int HALF_10K  = 2500;
    localparam int HALF_1HZ  = 25_000_000;

    localparam int MAX_CH    = 8;
    localparam int LOAD_CH_W = 3;

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, toggle, tick, reload
//
// Optional feature macro: CLK_DIV_RUNTIME_LOAD_EN (runtime half-period reload).
//
// Ports:
//   clk_in_50M  in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   count enable; counter and clk_out hold while low
//   sync_clr    in   synchronous phase realign (priority over en)
//   load_valid  in   reload strobe already decoded for this channel
//   load_half   in   new half-period (0 is clamped to 1)
//   clk_out     out  50% duty square clock
//   tick        out  one-cycle pulse on the clk_out 0->1 transition
//   load_pend   out  reload captured but not yet applied

module clk_div_chan #(
    parameter int               CNT_W    = 16,
    parameter logic [CNT_W-1:0] HALF_RST = CNT_W'(1)
) (
    input  logic             clk_in_50M,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] load_half,
    output logic             clk_out,
    output logic             tick,
    output logic             load_pend
);

    // A zero half-period would never match cnt == half-1 cleanly; treat as 1.
    localparam logic [CNT_W-1:0] HALF_RST_C = (HALF_RST == '0) ? CNT_W'(1) : HALF_RST;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic             wrap;

    assign wrap = (cnt == half - CNT_W'(1));

    always_ff @(posedge clk_in_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (sync_clr) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;    // high only when toggling up
            end else begin
                cnt     <= cnt + CNT_W'(1);
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

`ifdef CLK_DIV_RUNTIME_LOAD_EN
    logic [CNT_W-1:0] pend_half;
    logic             apply;

    // Reloads land only at a half-period boundary (or a realign), so the
    // running phase always completes and no runt pulse is produced.
    assign apply = sync_clr || (en && wrap);

    always_ff @(posedge clk_in_50M or negedge rst_n) begin
        if (!rst_n) begin
            half      <= HALF_RST_C;
            pend_half <= HALF_RST_C;
            load_pend <= 1'b0;
        end else begin
            if (apply && load_pend) begin
                half <= pend_half;
            end
            // A load coinciding with a wrap stays pending for the next wrap;
            // a later load simply overwrites an earlier unapplied one.
            if (load_valid) begin
                pend_half <= (load_half == '0) ? CNT_W'(1) : load_half;
                load_pend <= 1'b1;
            end else if (apply) begin
                load_pend <= 1'b0;
            end
        end
    end
`else
    logic unused_load;

    assign half        = HALF_RST_C;
    assign load_pend   = 1'b0;
    assign unused_load = ^{load_valid, load_half};
`endif

endmodule

// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - NUM_CH independent 50% duty clock dividers
//
// Optional feature macro: CLK_DIV_RUNTIME_LOAD_EN (runtime half-period reload;
// when undefined load_* are ignored and load_pend is 0).
//
// Ports:
//   clk_in_50M  in   50 MHz system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   global count enable
//   sync_clr    in   synchronous phase realign of all channels
//   load_valid  in   reload request strobe
//   load_ch     in   reload target channel (>= NUM_CH ignored)
//   load_half   in   reload half-period value
//   clk_out     out  square clock per channel
//   tick        out  one-cycle pulse per channel on clk_out rising
//   load_pend   out  per-channel reload pending flag

module clk_divider_multi
    import clk_div_pkg::*;
#(
    parameter int                        NUM_CH    = 2,
    parameter int                        CNT_W     = 16,
    parameter logic [NUM_CH*CNT_W-1:0]   HALF_INIT = {CNT_W'(HALF_10K), CNT_W'(HALF_1K)}
) (
    input  logic                 clk_in_50M,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sync_clr,
    input  logic                 load_valid,
    input  logic [LOAD_CH_W-1:0] load_ch,
    input  logic [CNT_W-1:0]     load_half,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    load_pend
);

`ifndef CLK_DIV_RUNTIME_LOAD_EN
    logic unused_load;
    assign unused_load = ^{load_valid, load_ch};
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic ch_load;

`ifdef CLK_DIV_RUNTIME_LOAD_EN
        // Out-of-range indices match no channel and are dropped.
        assign ch_load = load_valid && (load_ch == LOAD_CH_W'(c));
`else
        assign ch_load = 1'b0;
`endif

        clk_div_chan #(
            .CNT_W    (CNT_W),
            .HALF_RST (HALF_INIT[c*CNT_W +: CNT_W])
        ) u_chan (
            .clk_in_50M (clk_in_50M),
            .rst_n      (rst_n),
            .en         (en),
            .sync_clr   (sync_clr),
            .load_valid (ch_load),
            .load_half  (load_half),
            .clk_out    (clk_out[c]),
            .tick       (tick[c]),
            .load_pend  (load_pend[c])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// tb/tb_clk_divider_multi.sv - self-checking bench for clk_divider_multi

module tb_clk_divider_multi;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int H0     = 5;
    localparam int H1     = 3;
    localparam int LIMIT  = 200;

    logic              clk_in_50M = 1'b0;
    logic              rst_n      = 1'b0;
    logic              en         = 1'b0;
    logic              sync_clr   = 1'b0;
    logic              load_valid = 1'b0;
    logic [2:0]        load_ch    = '0;
    logic [CNT_W-1:0]  load_half  = '0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] load_pend;

    int n_checks = 0;
    int n_fail   = 0;

    clk_divider_multi #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .HALF_INIT ({16'd3, 16'd5})
    ) dut (
        .clk_in_50M (clk_in_50M),
        .rst_n      (rst_n),
        .en         (en),
        .sync_clr   (sync_clr),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_half  (load_half),
        .clk_out    (clk_out),
        .tick       (tick),
        .load_pend  (load_pend)
    );

    always #10 clk_in_50M = ~clk_in_50M;

    typedef struct {
        logic       en;
        logic       clr;
        int         cycles;
        logic [1:0] exp_clk;
        logic [1:0] exp_tick;
    } vec_t;

    vec_t vecs[19];

    task automatic step();
        @(posedge clk_in_50M);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic align_tick(input int ch);
        int n;
        n = 0;
        while (!tick[ch] && n < LIMIT) begin
            step();
            n++;
        end
        chk("align_tick_timeout", int'(n < LIMIT), 1);
    endtask

    // Samples from just after one tick up to and including the next one.
    task automatic measure(input int ch, output int per, output int hi);
        per = 0;
        hi  = 0;
        align_tick(ch);
        do begin
            step();
            per++;
            if (clk_out[ch]) hi++;
        end while (!tick[ch] && per < LIMIT);
    endtask

    // From the current sample, cycles until each channel's first tick.
    task automatic first_ticks(output int t0, output int t1);
        int n;
        t0 = -1;
        t1 = -1;
        n  = 0;
        while ((t0 < 0 || t1 < 0) && n < LIMIT) begin
            step();
            n++;
            if (tick[0] && t0 < 0) t0 = n;
            if (tick[1] && t1 < 0) t1 = n;
        end
    endtask

    initial begin
        int per, hi, t0, t1, n, bad;

        // ch0 half 5 (rise 5, fall 10, rise 15), ch1 half 3 (rise 3, 9, 15)
        vecs[0]  = '{1'b1, 1'b0, 3, 2'b10, 2'b10};
        vecs[1]  = '{1'b1, 1'b0, 1, 2'b10, 2'b00};
        vecs[2]  = '{1'b1, 1'b0, 1, 2'b11, 2'b01};
        vecs[3]  = '{1'b1, 1'b0, 1, 2'b01, 2'b00};
        vecs[4]  = '{1'b1, 1'b0, 3, 2'b11, 2'b10};
        vecs[5]  = '{1'b1, 1'b0, 1, 2'b10, 2'b00};
        vecs[6]  = '{1'b0, 1'b0, 4, 2'b10, 2'b00};
        vecs[7]  = '{1'b1, 1'b0, 2, 2'b00, 2'b00};
        vecs[8]  = '{1'b1, 1'b0, 3, 2'b11, 2'b11};
        vecs[9]  = '{1'b0, 1'b0, 1, 2'b11, 2'b00};
        vecs[10] = '{1'b1, 1'b0, 2, 2'b11, 2'b00};
        vecs[11] = '{1'b0, 1'b0, 5, 2'b11, 2'b00};
        vecs[12] = '{1'b1, 1'b0, 1, 2'b01, 2'b00};
        vecs[13] = '{1'b1, 1'b1, 1, 2'b00, 2'b00};
        vecs[14] = '{1'b1, 1'b0, 3, 2'b10, 2'b10};
        vecs[15] = '{1'b1, 1'b0, 2, 2'b11, 2'b01};
        vecs[16] = '{1'b0, 1'b1, 1, 2'b00, 2'b00};
        vecs[17] = '{1'b0, 1'b0, 3, 2'b00, 2'b00};
        vecs[18] = '{1'b1, 1'b0, 3, 2'b10, 2'b10};

        // Reset state
        step();
        step();
        chk("reset_clk_out", int'(clk_out), 0);
        chk("reset_tick", int'(tick), 0);
        chk("reset_load_pend", int'(load_pend), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            en       = vecs[i].en;
            sync_clr = vecs[i].clr;
            repeat (vecs[i].cycles) step();
            chk($sformatf("vec%0d_clk_out", i), int'(clk_out), int'(vecs[i].exp_clk));
            chk($sformatf("vec%0d_tick", i), int'(tick), int'(vecs[i].exp_tick));
            chk($sformatf("vec%0d_load_pend", i), int'(load_pend), 0);
        end
        sync_clr = 1'b0;
        en       = 1'b1;

        // Period and duty at the reset half-periods
        measure(0, per, hi);
        chk("ch0_period", per, 2 * H0);
        chk("ch0_high", hi, H0);
        measure(1, per, hi);
        chk("ch1_period", per, 2 * H1);
        chk("ch1_high", hi, H1);

        // en low for 7 cycles mid-period stretches the period by exactly 7
        align_tick(0);
        step();
        step();
        per = 2;
        en  = 1'b0;
        bad = 0;
        repeat (7) begin
            step();
            per++;
            if (tick != '0) bad++;
        end
        en = 1'b1;
        do begin
            step();
            per++;
        end while (!tick[0] && per < LIMIT);
        chk("en_hold_no_tick", bad, 0);
        chk("en_hold_period", per, 2 * H0 + 7);

        // sync_clr at an arbitrary phase realigns both channels
        repeat (4) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("sync_clr_clk_out", int'(clk_out), 0);
        chk("sync_clr_tick", int'(tick), 0);
        first_ticks(t0, t1);
        chk("sync_clr_first_tick0", t0, H0);
        chk("sync_clr_first_tick1", t1, H1);

`ifdef CLK_DIV_RUNTIME_LOAD_EN
        // ch1 reload to 2: pending until the next ch1 toggle, then period 4
        align_tick(1);
        load_valid = 1'b1;
        load_ch    = 3'd1;
        load_half  = 16'd2;
        step();
        load_valid = 1'b0;
        chk("load1_pend", int'(load_pend), 2);
        n = 0;
        while (load_pend[1] && n < LIMIT) begin
            step();
            n++;
        end
        chk("load1_apply_delay", n, 2);
        chk("load1_apply_clk", int'(clk_out[1]), 0);
        measure(1, per, hi);
        chk("load1_period", per, 4);
        chk("load1_high", hi, 2);

        // ch0 reload to 0 clamps to 1: clk/2
        load_valid = 1'b1;
        load_ch    = 3'd0;
        load_half  = 16'd0;
        step();
        load_valid = 1'b0;
        chk("load0_pend", int'(load_pend[0]), 1);
        n = 0;
        while (load_pend[0] && n < LIMIT) begin
            step();
            n++;
        end
        chk("load0_apply_timeout", int'(n < LIMIT), 1);
        measure(0, per, hi);
        chk("load0_period", per, 2);
        chk("load0_high", hi, 1);

        // Out-of-range channel index is ignored
        load_valid = 1'b1;
        load_ch    = 3'd5;
        load_half  = 16'd9;
        step();
        load_valid = 1'b0;
        chk("load_bad_ch_pend", int'(load_pend), 0);

        // Leave a reload pending for the reset check below
        align_tick(1);
        load_valid = 1'b1;
        load_ch    = 3'd1;
        load_half  = 16'd7;
        step();
        load_valid = 1'b0;
        chk("load_before_reset_pend", int'(load_pend), 2);
`else
        // Reload inputs have no effect in this build
        load_valid = 1'b1;
        load_ch    = 3'd0;
        load_half  = 16'd1;
        step();
        load_valid = 1'b0;
        chk("load_ignored_pend", int'(load_pend), 0);
        measure(0, per, hi);
        chk("load_ignored_period", per, 2 * H0);
`endif

        // Asynchronous reset mid-period
        align_tick(0);
        step();
        #3;
        rst_n = 1'b0;
        #2;
        chk("async_reset_clk_out", int'(clk_out), 0);
        chk("async_reset_tick", int'(tick), 0);
        chk("async_reset_load_pend", int'(load_pend), 0);
        step();
        rst_n = 1'b1;
        first_ticks(t0, t1);
        chk("post_reset_first_tick0", t0, H0);
        chk("post_reset_first_tick1", t1, H1);
        measure(1, per, hi);
        chk("post_reset_ch1_period", per, 2 * H1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
